// File: rtl/alu_pkg.sv
// Shared op encodings, FSM state and result-entry types for the ALU issue stage.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int TAG_W  = 4;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_MOD = 3'b110;
    localparam logic [2:0] OP_AND = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              err;
    } result_t;

    // Ops whose divisor must be screened for zero before the ALU result is trusted.
    function automatic logic is_div_class(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Command, ALU-drive and result buses of the issue stage; slave is the stage side.
interface alu_issue_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
);

    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic [TAG_W-1:0]  in_tag;

    logic [WIDTH-1:0]  alu_din1;
    logic [WIDTH-1:0]  alu_din2;
    logic [2:0]        alu_ms;
    logic [WIDTH-1:0]  alu_out;

    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, alu_out, out_ready,
        output in_ready, alu_din1, alu_din2, alu_ms, out_valid, out_data, out_tag, out_err
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, alu_out, out_ready,
        input  in_ready, alu_din1, alu_din2, alu_ms, out_valid, out_data, out_tag, out_err
    );

endinterface

// File: rtl/alu_result_fifo.sv
// Small result queue; the head is presented straight from storage so it is registered.
module alu_result_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = logic
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  entry_t                 entry_in,
    output entry_t                 entry_out,
    output logic [$clog2(DEPTH):0] count,
    output logic                   valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && ((count_reg != FULL) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while the count says they are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= entry_in;
        end
    end

    assign count     = count_reg;
    assign valid     = (count_reg != '0);
    assign entry_out = valid ? mem[rd_ptr_reg] : '0;

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage: registers one command onto the ALU, holds it for EXEC_CYCLES, screens and queues the result.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int EXEC_CYCLES = 2,
    parameter int DEPTH       = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_issue_if.slave    bus
);

    localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);
    localparam logic [$clog2(DEPTH):0] FIFO_FULL = ($clog2(DEPTH)+1)'(DEPTH);

    state_t               state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [WIDTH-1:0]     din1_reg;
    logic [WIDTH-1:0]     din2_reg;
    logic [2:0]           ms_reg;
    logic [TAG_W-1:0]     tag_reg;
    logic                 ready_en_reg;

    logic                 accept;
    logic                 capture;
    result_t              push_entry;
    result_t              head_entry;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                 fifo_valid;

    // ready_en_reg keeps in_ready low until the first edge after reset release.
    assign bus.in_ready = ready_en_reg && (state_reg == IDLE) && (fifo_count < FIFO_FULL);
    assign accept       = bus.in_valid && bus.in_ready;
    assign capture      = (state_reg == EXEC) && (cnt_reg == '0);

    always_comb begin
        push_entry      = '0;
        push_entry.tag  = tag_reg;
        if (ms_reg == OP_NOP) begin
            push_entry.data = '0;
            push_entry.err  = 1'b1;
        end else if (is_div_class(ms_reg) && (din2_reg == '0)) begin
            push_entry.data = '1;
            push_entry.err  = 1'b1;
        end else begin
            push_entry.data = bus.alu_out;
            push_entry.err  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            din1_reg     <= '0;
            din2_reg     <= '0;
            ms_reg       <= '0;
            tag_reg      <= '0;
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg <= EXEC;
                        din1_reg  <= bus.in_a;
                        din2_reg  <= bus.in_b;
                        ms_reg    <= bus.in_op;
                        tag_reg   <= bus.in_tag;
                        cnt_reg   <= CNT_LOAD;
                    end
                end
                EXEC: begin
                    if (cnt_reg == '0) begin
                        // Parking the ALU on all-zero inputs keeps its output quiet between ops.
                        state_reg <= IDLE;
                        din1_reg  <= '0;
                        din2_reg  <= '0;
                        ms_reg    <= '0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    alu_result_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (result_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (capture),
        .pop       (bus.out_valid && bus.out_ready),
        .entry_in  (push_entry),
        .entry_out (head_entry),
        .count     (fifo_count),
        .valid     (fifo_valid)
    );

    assign bus.alu_din1  = din1_reg;
    assign bus.alu_din2  = din2_reg;
    assign bus.alu_ms    = ms_reg;
    assign bus.out_valid = fifo_valid;
    assign bus.out_data  = head_entry.data;
    assign bus.out_tag   = head_entry.tag;
    assign bus.out_err   = head_entry.err;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU and an in-order result scoreboard.
module tb_alu_issue_stage;
    import alu_pkg::*;

    localparam int WIDTH       = 16;
    localparam int EXEC_CYCLES = 2;
    localparam int DEPTH       = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_if #(.WIDTH(WIDTH)) bus ();

    alu_issue_stage #(
        .WIDTH       (WIDTH),
        .EXEC_CYCLES (EXEC_CYCLES),
        .DEPTH       (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural ALU; divide/modulo by zero returns junk that the stage must screen out.
    always_comb begin
        bus.alu_out = '0;
        case (bus.alu_ms)
            OP_ADD: bus.alu_out = bus.alu_din1 + bus.alu_din2;
            OP_SUB: bus.alu_out = bus.alu_din1 - bus.alu_din2;
            OP_MUL: bus.alu_out = bus.alu_din1 * bus.alu_din2;
            OP_DIV: bus.alu_out = (bus.alu_din2 == '0) ? 16'h1234 : bus.alu_din1 / bus.alu_din2;
            OP_XOR: bus.alu_out = bus.alu_din1 ^ bus.alu_din2;
            OP_MOD: bus.alu_out = (bus.alu_din2 == '0) ? 16'h1234 : bus.alu_din1 % bus.alu_din2;
            OP_AND: bus.alu_out = bus.alu_din1 & bus.alu_din2;
            default: bus.alu_out = '0;
        endcase
    end

    int      checks = 0;
    int      errors = 0;
    result_t sb[$];
    result_t pending;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    // One cycle: score a head being popped, record an accept, advance to the next falling edge.
    task automatic tick();
        logic    acc;
        result_t head;
        acc = bus.in_valid && bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", 32'(bus.out_valid), 32'd0);
            end else begin
                head = sb.pop_front();
                check("out_data", 32'(bus.out_data), 32'(head.data));
                check("out_tag",  32'(bus.out_tag),  32'(head.tag));
                check("out_err",  32'(bus.out_err),  32'(head.err));
                $display("result tag=%0h data=%0h err=%0b", bus.out_tag, bus.out_data, bus.out_err);
            end
        end
        if (acc) begin
            sb.push_back(pending);
            $display("accept op=%0b a=%0h b=%0h tag=%0h", bus.in_op, bus.in_a, bus.in_b, bus.in_tag);
        end
        @(posedge clk);
        @(negedge clk);
        if (acc) bus.in_valid = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] tag, input logic [15:0] exp_data, input logic exp_err);
        int n;
        n = 0;
        pending      = '{data: exp_data, tag: tag, err: exp_err};
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        check("accept_timeout", 32'(bus.in_ready), 32'd1);
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        check("drain_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_out_tag",   32'(bus.out_tag),   32'd0);
        check("rst_out_err",   32'(bus.out_err),   32'd0);
        check("rst_alu_din1",  32'(bus.alu_din1),  32'd0);
        check("rst_alu_din2",  32'(bus.alu_din2),  32'd0);
        check("rst_alu_ms",    32'(bus.alu_ms),    32'd0);
        rst_n = 1'b1;
        #1;
        check("release_in_ready_before_edge", 32'(bus.in_ready), 32'd0);
        tick();
        check("release_in_ready", 32'(bus.in_ready), 32'd1);

        // Single add with exact latency
        bus.out_ready = 1'b1;
        pending      = '{data: 16'd7, tag: 4'd5, err: 1'b0};
        bus.in_op    = OP_ADD;
        bus.in_a     = 16'd3;
        bus.in_b     = 16'd4;
        bus.in_tag   = 4'd5;
        bus.in_valid = 1'b1;
        tick();
        check("lat_alu_din1", 32'(bus.alu_din1), 32'd3);
        check("lat_alu_din2", 32'(bus.alu_din2), 32'd4);
        check("lat_alu_ms",   32'(bus.alu_ms),   32'(OP_ADD));
        check("lat_busy",     32'(bus.in_ready), 32'd0);
        check("lat_valid_k",  32'(bus.out_valid), 32'd0);
        tick();
        check("lat_valid_k1", 32'(bus.out_valid), 32'd0);
        check("lat_busy_k1",  32'(bus.in_ready),  32'd0);
        tick();
        check("lat_valid_k2", 32'(bus.out_valid), 32'd1);
        tick();
        check("lat_valid_k3", 32'(bus.out_valid), 32'd0);
        check("idle_alu_din1", 32'(bus.alu_din1), 32'd0);
        check("idle_alu_ms",   32'(bus.alu_ms),   32'd0);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // Error screening, arithmetic and truncation
        issue(OP_DIV, 16'd100,   16'd0,     4'h1, 16'hFFFF, 1'b1);
        issue(OP_MOD, 16'd7,     16'd0,     4'h2, 16'hFFFF, 1'b1);
        issue(OP_DIV, 16'd100,   16'd7,     4'h3, 16'd14,   1'b0);
        issue(OP_MOD, 16'd100,   16'd7,     4'h4, 16'd2,    1'b0);
        issue(OP_MUL, 16'h0100,  16'h0100,  4'h5, 16'h0000, 1'b0);
        issue(OP_SUB, 16'd0,     16'd1,     4'h6, 16'hFFFF, 1'b0);
        issue(OP_NOP, 16'd9,     16'd9,     4'h7, 16'h0000, 1'b1);
        issue(OP_DIV, 16'd50,    16'd0,     4'h8, 16'hFFFF, 1'b1);
        issue(OP_XOR, 16'hA5A5,  16'h0FF0,  4'h9, 16'hAA55, 1'b0);
        issue(OP_AND, 16'hF0F0,  16'h3C3C,  4'hA, 16'h3030, 1'b0);
        drain();

        // Backpressure: two fill the queue, the third waits while the head stays put
        bus.out_ready = 1'b0;
        issue(OP_ADD, 16'd1, 16'd1, 4'h1, 16'd2, 1'b0);
        issue(OP_SUB, 16'd9, 16'd4, 4'h2, 16'd5, 1'b0);
        pending      = '{data: 16'hFF00, tag: 4'h3, err: 1'b0};
        bus.in_op    = OP_XOR;
        bus.in_a     = 16'hF0F0;
        bus.in_b     = 16'h0FF0;
        bus.in_tag   = 4'h3;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("full_in_ready",  32'(bus.in_ready),  32'd0);
            check("full_out_valid", 32'(bus.out_valid), 32'd1);
            check("full_head_data", 32'(bus.out_data),  32'd2);
            check("full_head_tag",  32'(bus.out_tag),   32'd1);
            tick();
        end
        bus.out_ready = 1'b1;
        drain();
        check("third_accepted", 32'(bus.in_valid), 32'd0);

        // Pop and capture-push on the same edge
        bus.out_ready = 1'b0;
        issue(OP_AND, 16'hFFFF, 16'h00FF, 4'h4, 16'h00FF, 1'b0);
        tick();
        tick();
        issue(OP_MUL, 16'd3, 16'd5, 4'h6, 16'd15, 1'b0);
        tick();
        bus.out_ready = 1'b1;
        tick();
        check("pushpop_valid", 32'(bus.out_valid), 32'd1);
        check("pushpop_tag",   32'(bus.out_tag),   32'd6);
        check("pushpop_data",  32'(bus.out_data),  32'd15);
        drain();

        // Reset during EXEC with one result queued
        bus.out_ready = 1'b0;
        issue(OP_ADD, 16'd1, 16'd2, 4'h7, 16'd3, 1'b0);
        tick();
        tick();
        issue(OP_ADD, 16'd5, 16'd5, 4'h8, 16'd10, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready",  32'(bus.in_ready),  32'd0);
        check("midrst_alu_ms",    32'(bus.alu_ms),    32'd0);
        check("midrst_alu_din1",  32'(bus.alu_din1),  32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("postrst_no_stale", 32'(bus.out_valid), 32'd0);
            tick();
        end
        issue(OP_ADD, 16'd10, 16'd20, 4'h9, 16'd30, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
